fpga_mem_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single-word FPGA memory master port (27-bit byte address, 32-bit data, burstcount 1, pipelined readdatavalid) between two FPGA-side requesters, e.g. the host-interface DMA and a debug/monitor agent. It uses round-robin grant and registers the command onto the shared master. A tag FIFO routes each returning read word back to the requester that issued it. It sits in the clk100 domain between the requesters and the fpga_mem conduit.

---
 rtl/fpga_mem_arbiter.sv | 114 +++++++++++
 tb/tb_fpga_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_mem_arbiter.sv
// fpga_mem_arbiter: round-robin arbiter sharing one Avalon-MM master between two requesters,
// with a tag FIFO steering pipelined read returns back to the issuing requester.
module fpga_mem_arbiter #(
    parameter  int ADDR_W      = 27,
    parameter  int DATA_W      = 32,
    parameter  int MAX_PENDING = 4,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic                clk100_clk,
    input  logic                reset_clk100_reset_n,
    input  logic [1:0]          s_read,
    input  logic [1:0]          s_write,
    input  logic [2*ADDR_W-1:0] s_address,
    input  logic [2*DATA_W-1:0] s_writedata,
    input  logic [2*BE_W-1:0]   s_byteenable,
    output logic [1:0]          s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          s_readdatavalid,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [BE_W-1:0]     m_byteenable,
    output logic                m_read,
    output logic                m_write,
    output logic                m_burstcount,
    output logic                err_unexp_rdv
);
    localparam int PTR_W = MAX_PENDING > 1 ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    typedef enum logic {IDLE, CMD} state_e;
    state_e state_q, state_d;

    logic              last_grant_q, gnt, gnt_vld, push, pop, done;
    logic [1:0]        elig;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              tag_q [MAX_PENDING];
    logic              m_read_q, m_write_q, err_q;
    logic [ADDR_W-1:0] m_address_q;
    logic [DATA_W-1:0] m_writedata_q;
    logic [BE_W-1:0]   m_byteenable_q;

    // A full tag FIFO only disqualifies reads; writes never need a return slot.
    assign elig = s_write | (s_read & {2{count_q < CNT_W'(MAX_PENDING)}});
    assign gnt  = (elig == 2'b11) ? ~last_grant_q : elig[1];
    assign done = (state_q == CMD) && !m_waitrequest;
    assign push = done && m_read_q;
    assign pop  = m_readdatavalid && (count_q != '0);

    always_ff @(posedge clk100_clk or negedge reset_clk100_reset_n) begin
        if (!reset_clk100_reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && |elig) state_d = CMD;
        else if (done) state_d = IDLE;
    end

    always_comb begin
        gnt_vld         = (state_q == IDLE) && |elig;
        s_waitrequest   = gnt_vld ? (gnt ? 2'b01 : 2'b10) : 2'b11;
        s_readdatavalid = pop ? (tag_q[rd_ptr_q] ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk100_clk or negedge reset_clk100_reset_n) begin
        if (!reset_clk100_reset_n) begin
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            m_byteenable_q <= '0;
            last_grant_q   <= 1'b1;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            if (gnt_vld) begin
                m_address_q    <= gnt ? s_address[ADDR_W +: ADDR_W] : s_address[0 +: ADDR_W];
                m_writedata_q  <= gnt ? s_writedata[DATA_W +: DATA_W] : s_writedata[0 +: DATA_W];
                m_byteenable_q <= gnt ? s_byteenable[BE_W +: BE_W] : s_byteenable[0 +: BE_W];
                m_write_q      <= s_write[gnt];
                m_read_q       <= ~s_write[gnt];
                last_grant_q   <= gnt;
            end else if (done) begin
                m_read_q  <= 1'b0;
                m_write_q <= 1'b0;
            end
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (m_readdatavalid && count_q == '0) err_q <= 1'b1;
        end
    end

    // The tag issued is last_grant_q, which still names the requester of the command in flight.
    always_ff @(posedge clk100_clk) begin
        if (push) tag_q[wr_ptr_q] <= last_grant_q;
    end

    assign s_readdata    = m_readdata;
    assign m_address     = m_address_q;
    assign m_writedata   = m_writedata_q;
    assign m_byteenable  = m_byteenable_q;
    assign m_read        = m_read_q;
    assign m_write       = m_write_q;
    assign m_burstcount  = 1'b1;
    assign err_unexp_rdv = err_q;
endmodule

// File: tb/tb_fpga_mem_arbiter.sv
// tb_fpga_mem_arbiter: table vectors plus hand sequences; master commands and read returns
// are checked against scoreboard queues filled when stimulus is driven.
module tb_fpga_mem_arbiter;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    s_read = '0, s_write = '0;
    logic [2*AW-1:0] s_address = '0;
    logic [2*DW-1:0] s_writedata = '0;
    logic [2*BW-1:0] s_byteenable = '0;
    logic [1:0]    s_waitrequest, s_readdatavalid;
    logic [DW-1:0] s_readdata;
    logic          m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
    logic [DW-1:0] m_readdata = '0;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic [BW-1:0] m_byteenable;
    logic          m_read, m_write, m_burstcount, err_unexp_rdv;

    int total = 0;
    int bad = 0;

    typedef struct {logic wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be;} cmd_t;
    typedef struct {logic [1:0] rdv; logic [DW-1:0] d;} ret_t;
    typedef struct {
        logic [1:0] rd, wr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [BW-1:0] be0, be1;
        logic [1:0] ew;
    } vec_t;

    cmd_t exp_cmd[$];
    ret_t exp_ret[$];
    cmd_t ce, mc;
    ret_t re;
    vec_t v[8];
    logic g;

    fpga_mem_arbiter dut (
        .clk100_clk(clk), .reset_clk100_reset_n(rst_n),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_burstcount(m_burstcount),
        .err_unexp_rdv(err_unexp_rdv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be);
        mc.wr = wr; mc.a = a; mc.d = d; mc.be = be;
        exp_cmd.push_back(mc);
    endtask

    task automatic push_ret(input logic [1:0] rdv, input logic [DW-1:0] d);
        ret_t r;
        r.rdv = rdv; r.d = d;
        exp_ret.push_back(r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_read = '0; s_write = '0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
        @(negedge clk);
        chk("rst_mrw", 64'({m_read, m_write}), 64'd0);
        chk("rst_fields", 64'({m_address, m_writedata, m_byteenable}), 64'd0);
        chk("rst_wait", 64'(s_waitrequest), 64'd3);
        chk("rst_rdv_err", 64'({s_readdatavalid, err_unexp_rdv}), 64'd0);
        chk("burstcount", 64'(m_burstcount), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard: a master command is consumed on the cycle it completes.
    always @(negedge clk) if (rst_n) begin
        if ((m_read || m_write) && !m_waitrequest) begin
            if (exp_cmd.size() == 0) chk("cmd_unexpected", 64'({m_read, m_write}), 64'd0);
            else begin
                ce = exp_cmd.pop_front();
                chk("cmd_type", 64'({m_read, m_write}), ce.wr ? 64'd1 : 64'd2);
                chk("cmd_addr", 64'(m_address), 64'(ce.a));
                if (ce.wr) chk("cmd_wdata_be", 64'({m_writedata, m_byteenable}), 64'({ce.d, ce.be}));
            end
        end
        if (s_readdatavalid != 2'b00) begin
            if (exp_ret.size() == 0) chk("ret_unexpected", 64'(s_readdatavalid), 64'd0);
            else begin
                re = exp_ret.pop_front();
                chk("ret_tag", 64'(s_readdatavalid), 64'(re.rdv));
                chk("ret_data", 64'(s_readdata), 64'(re.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{2'b00, 2'b01, 27'h100, 27'h0,   32'hDEADBEEF, 32'h0,        4'hF, 4'h0, 2'b10};
        v[1] = '{2'b00, 2'b11, 27'h200, 27'h300, 32'h00000001, 32'h00000002, 4'h3, 4'hC, 2'b01};
        v[2] = '{2'b10, 2'b00, 27'h0,   27'h40,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01};
        v[3] = '{2'b01, 2'b10, 27'h50,  27'h60,  32'h0,        32'h00000005, 4'h0, 4'h8, 2'b10};
        v[4] = '{2'b01, 2'b01, 27'h70,  27'h0,   32'h00000007, 32'h0,        4'h1, 4'h0, 2'b10};
        v[5] = '{2'b11, 2'b00, 27'h80,  27'h90,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01};
        v[6] = '{2'b00, 2'b00, 27'hA0,  27'hB0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b11};
        v[7] = '{2'b10, 2'b01, 27'hC0,  27'hD0,  32'h0000000C, 32'h0,        4'h2, 4'h0, 2'b10};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_read = v[i].rd; s_write = v[i].wr;
            s_address = {v[i].a1, v[i].a0};
            s_writedata = {v[i].d1, v[i].d0};
            s_byteenable = {v[i].be1, v[i].be0};
            g = (v[i].ew == 2'b01);
            if (v[i].ew != 2'b11)
                push_cmd(v[i].wr[g], g ? v[i].a1 : v[i].a0, g ? v[i].d1 : v[i].d0, g ? v[i].be1 : v[i].be0);
            @(negedge clk);
            chk($sformatf("vec%0d_wait", i), 64'(s_waitrequest), 64'(v[i].ew));
            tick();
            s_read = '0; s_write = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_cmd_wait", i), 64'(s_waitrequest), 64'd3);
            tick();
            if (v[i].ew != 2'b11 && !v[i].wr[g]) begin
                m_readdatavalid = 1'b1;
                m_readdata = 32'hA0000000 + i;
                push_ret(g ? 2'b10 : 2'b01, 32'hA0000000 + i);
            end
            tick();
            m_readdatavalid = 1'b0;
        end

        // Post-reset contention: both read, s0 first, then s1; data returns in order.
        do_reset();
        s_read = 2'b11; s_address = {27'h20, 27'h10};
        push_cmd(1'b0, 27'h10, 32'h0, 4'h0);
        push_cmd(1'b0, 27'h20, 32'h0, 4'h0);
        @(negedge clk); chk("cont_g0", 64'(s_waitrequest), 64'd2);
        tick(); s_read = 2'b10;
        @(negedge clk); chk("cont_cmd0", 64'(s_waitrequest), 64'd3);
        tick();
        @(negedge clk); chk("cont_g1", 64'(s_waitrequest), 64'd1);
        tick(); s_read = 2'b00;
        tick();
        m_readdatavalid = 1'b1; m_readdata = 32'h11111111; push_ret(2'b01, 32'h11111111);
        tick();
        m_readdata = 32'h22222222; push_ret(2'b10, 32'h22222222);
        tick();
        m_readdatavalid = 1'b0;

        // Fairness: continuous writes from both alternate 0,1,0,1 over 8 commands.
        do_reset();
        s_write = 2'b11; s_address = {27'h400, 27'h300};
        s_writedata = {32'h000000B1, 32'h000000A0}; s_byteenable = 8'hFF;
        for (int k = 0; k < 8; k++)
            push_cmd(1'b1, k[0] ? 27'h400 : 27'h300, k[0] ? 32'hB1 : 32'hA0, 4'hF);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("fair_c%0d", k), 64'(s_waitrequest),
                k[0] ? 64'd3 : (k[1] ? 64'd1 : 64'd2));
            tick();
        end
        s_write = 2'b00;
        tick();

        // Backpressure: command held 5 cycles, completes on the 6th; s1 waits.
        do_reset();
        s_write = 2'b01; s_address = {27'h666, 27'h555};
        s_writedata = {32'h9ABCDEF0, 32'h12345678}; s_byteenable = 8'h96;
        m_waitrequest = 1'b1;
        push_cmd(1'b1, 27'h555, 32'h12345678, 4'h6);
        push_cmd(1'b1, 27'h666, 32'h9ABCDEF0, 4'h9);
        @(negedge clk); chk("bp_grant", 64'(s_waitrequest), 64'd2);
        tick(); s_write = 2'b10;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) m_waitrequest = 1'b0;
            @(negedge clk);
            chk($sformatf("bp_mwrite%0d", k), 64'({m_read, m_write}), 64'd1);
            chk($sformatf("bp_fields%0d", k), 64'({m_address, m_writedata, m_byteenable}),
                64'({27'h555, 32'h12345678, 4'h6}));
            chk($sformatf("bp_wait%0d", k), 64'(s_waitrequest), 64'd3);
            tick();
        end
        @(negedge clk); chk("bp_s1_grant", 64'(s_waitrequest), 64'd1);
        tick(); s_write = 2'b00;
        tick();

        // Pending limit: four outstanding reads block the fifth, not a write.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            s_read = 2'b01; s_address = {27'h0, 27'h700 + 27'(r)};
            push_cmd(1'b0, 27'h700 + 27'(r), 32'h0, 4'h0);
            @(negedge clk); chk($sformatf("pend_g%0d", r), 64'(s_waitrequest), 64'd2);
            tick(); s_read = 2'b00;
            tick();
        end
        s_read = 2'b01; s_write = 2'b10;
        s_address = {27'h7AA, 27'h7FF}; s_writedata = {32'h0000CAFE, 32'h0}; s_byteenable = 8'hF0;
        push_cmd(1'b1, 27'h7AA, 32'h0000CAFE, 4'hF);
        @(negedge clk); chk("full_wr_grant", 64'(s_waitrequest), 64'd1);
        tick(); s_write = 2'b00;
        @(negedge clk); chk("full_cmd", 64'(s_waitrequest), 64'd3);
        tick();
        m_readdatavalid = 1'b1; m_readdata = 32'h44440000; push_ret(2'b01, 32'h44440000);
        @(negedge clk); chk("full_stall", 64'(s_waitrequest), 64'd3);
        tick(); m_readdatavalid = 1'b0;
        push_cmd(1'b0, 27'h7FF, 32'h0, 4'h0);
        @(negedge clk); chk("after_pop_grant", 64'(s_waitrequest), 64'd2);
        tick(); s_read = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            m_readdatavalid = 1'b1; m_readdata = 32'h55550000 + k;
            push_ret(2'b01, 32'h55550000 + k);
            tick();
        end
        m_readdatavalid = 1'b0;
        tick();

        // Spurious return, then reset mid-CMD discards outstanding reads.
        do_reset();
        m_readdatavalid = 1'b1; m_readdata = 32'h00000BAD;
        @(negedge clk);
        chk("spur_rdv", 64'(s_readdatavalid), 64'd0);
        chk("spur_err_pre", 64'(err_unexp_rdv), 64'd0);
        tick(); m_readdatavalid = 1'b0;
        @(negedge clk); chk("spur_err", 64'(err_unexp_rdv), 64'd1);
        tick();
        s_read = 2'b01; s_address = {27'h0, 27'h10};
        push_cmd(1'b0, 27'h10, 32'h0, 4'h0);
        tick(); s_read = 2'b00;
        tick();
        s_write = 2'b01; s_address = {27'h0, 27'h20}; m_waitrequest = 1'b1;
        tick(); s_write = 2'b00;
        @(negedge clk); chk("mid_cmd_mwrite", 64'(m_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mwrite", 64'(m_write), 64'd0);
        chk("rst_mid_err", 64'(err_unexp_rdv), 64'd0);
        chk("rst_mid_wait", 64'(s_waitrequest), 64'd3);
        tick(); tick();
        rst_n = 1'b1; m_waitrequest = 1'b0;
        tick();
        m_readdatavalid = 1'b1; m_readdata = 32'h0000DEAD;
        @(negedge clk); chk("post_rst_rdv", 64'(s_readdatavalid), 64'd0);
        tick(); m_readdatavalid = 1'b0;
        @(negedge clk); chk("post_rst_err", 64'(err_unexp_rdv), 64'd1);
        tick(); tick();

        chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        chk("ret_queue_drained", 64'(exp_ret.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
